// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detection controller.
//   state_e     : controller state encoding (IDLE/ARM/RUN/DONE)
//   DEF_PAT_W   : default maximum pattern length in bits
//   DEF_CNT_W   : default match target / counter width
//   cfg_legal() : run-configuration legality check applied at start
package seq_det_pkg;

    localparam int unsigned DEF_PAT_W = 8;
    localparam int unsigned DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    // A run needs a non-empty pattern that fits the history and a non-zero hit budget.
    function automatic logic cfg_legal(input int unsigned len,
                                       input int unsigned max_len,
                                       input int unsigned target);
        return (len != 0) && (len <= max_len) && (target != 0);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Shift-register match core: keeps the most recent serial bits and flags when
// the last len_i bits equal the low len_i bits of the pattern.
//   clk, rst_n   : clock, async active-low reset
//   clear_i      : synchronous clear of history and fill count
//   shift_i      : accept x_i this cycle
//   x_i          : serial data bit
//   overlap_i    : 0 restarts the fill count after each match
//   pattern_i    : pattern, bit len-1 is the oldest bit
//   len_i        : active pattern length
//   match_c_o    : combinational match for the bit presented this cycle
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = DEF_PAT_W,
    parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             shift_i,
    input  logic             x_i,
    input  logic             overlap_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             match_c_o
);

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill_q, fill_d, fill_inc;

    // Thermometer mask selecting the len_i youngest history bits.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (i < 32'(len_i));
        end
    end

    // Post-shift view of history and fill; the match decision uses these.
    always_comb begin
        hist_d    = {hist_q[PAT_W-2:0], x_i};
        fill_inc  = (fill_q >= len_i) ? len_i : fill_q + LEN_W'(1);
        match_c_o = (fill_inc == len_i) && (((hist_d ^ pattern_i) & mask) == '0);
        fill_d    = (match_c_o && !overlap_i) ? '0 : fill_inc;
    end

    // History and fill registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clear_i) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift_i) begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Programmable serial-pattern detection controller: holds the run configuration,
// sequences the match core, counts matches and finishes after a hit budget.
//   clk, rst     : clock, async active-low reset
//   cfg_*        : pattern, length, target and overlap policy (latched in IDLE)
//   start, abort : run control
//   x, x_valid   : serial input and its qualifier
//   z            : one-cycle match pulse
//   busy         : run in progress (ARM or RUN)
//   done         : one-cycle pulse when the target is reached
//   err_cfg      : one-cycle pulse when start is rejected
//   match_cnt    : matches in the current or last run
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = DEF_PAT_W,
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             cfg_overlap,
    input  logic             start,
    input  logic             abort,
    input  logic             x,
    input  logic             x_valid,
    output logic             z,
    output logic             busy,
    output logic             done,
    output logic             err_cfg,
    output logic [CNT_W-1:0] match_cnt
);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             overlap_q, overlap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             z_q, z_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             core_clear, core_shift, match_c;

    seq_match_core #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst),
        .clear_i   (core_clear),
        .shift_i   (core_shift),
        .x_i       (x),
        .overlap_i (overlap_q),
        .pattern_i (pattern_q),
        .len_i     (len_q),
        .match_c_o (match_c)
    );

    // Next-state, configuration and output decode.
    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        len_d      = len_q;
        target_d   = target_q;
        overlap_d  = overlap_q;
        cnt_d      = cnt_q;
        z_d        = 1'b0;
        err_d      = 1'b0;
        core_clear = 1'b0;
        core_shift = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Start is judged against the config already held, even if a
                // write lands on the same edge.
                if (start && !abort) begin
                    if (cfg_legal(32'(len_q), PAT_W, 32'(target_q))) begin
                        state_d = ARM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (cfg_we) begin
                    pattern_d = cfg_pattern;
                    len_d     = cfg_len;
                    target_d  = cfg_target;
                    overlap_d = cfg_overlap;
                end
            end
            ARM: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    core_clear = 1'b1;
                    cnt_d      = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (x_valid) begin
                    core_shift = 1'b1;
                    if (match_c) begin
                        z_d   = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == target_q) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ARM) || (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State, configuration and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            target_q  <= '0;
            overlap_q <= 1'b0;
            cnt_q     <= '0;
            z_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            target_q  <= target_d;
            overlap_q <= overlap_d;
            cnt_q     <= cnt_d;
            z_q       <= z_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign z         = z_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_cfg   = err_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios plus random traffic
// compared every cycle against a bit-queue reference model.
module tb_seq_det_ctrl;

    localparam int unsigned PAT_W = 8;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned LEN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_target;
    logic             cfg_overlap;
    logic             start;
    logic             abort;
    logic             x;
    logic             x_valid;
    logic             z;
    logic             busy;
    logic             done;
    logic             err_cfg;
    logic [CNT_W-1:0] match_cnt;

    always #5 clk = ~clk;

    seq_det_ctrl #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_target  (cfg_target),
        .cfg_overlap (cfg_overlap),
        .start       (start),
        .abort       (abort),
        .x           (x),
        .x_valid     (x_valid),
        .z           (z),
        .busy        (busy),
        .done        (done),
        .err_cfg     (err_cfg),
        .match_cnt   (match_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got=%0d exp=%0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 arm, 2 run, 3 done; received bits kept in a queue.
    int         m_phase;
    logic [7:0] m_pat;
    int         m_len;
    int         m_tgt;
    bit         m_ov;
    int         m_cnt;
    bit         m_q[$];
    bit         e_z, e_busy, e_done, e_err;

    task automatic model_reset();
        m_phase = 0; m_pat = '0; m_len = 0; m_tgt = 0; m_ov = 0; m_cnt = 0;
        m_q.delete();
        e_z = 0; e_busy = 0; e_done = 0; e_err = 0;
    endtask

    function automatic bit tail_hits();
        for (int k = 0; k < m_len; k++) begin
            if (m_q[k] != m_pat[m_len - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int nph;
        nph = m_phase;
        e_z = 0;
        e_err = 0;
        case (m_phase)
            0: begin
                if (start && !abort) begin
                    if (m_len == 0 || m_len > PAT_W || m_tgt == 0) e_err = 1;
                    else nph = 1;
                end
                if (cfg_we) begin
                    m_pat = cfg_pattern; m_len = int'(cfg_len);
                    m_tgt = int'(cfg_target); m_ov = cfg_overlap;
                end
            end
            1: begin
                if (abort) nph = 0;
                else begin
                    m_q.delete(); m_cnt = 0; nph = 2;
                end
            end
            2: begin
                if (abort) nph = 0;
                else if (x_valid) begin
                    m_q.push_back(x);
                    if (m_q.size() > m_len) void'(m_q.pop_front());
                    if (m_q.size() == m_len && tail_hits()) begin
                        e_z = 1;
                        m_cnt++;
                        if (!m_ov) m_q.delete();
                        if (m_cnt == m_tgt) nph = 3;
                    end
                end
            end
            default: nph = 0;
        endcase
        m_phase = nph;
        e_busy = (nph == 1 || nph == 2);
        e_done = (nph == 3);
    endtask

    task automatic compare_all(input string pfx);
        check({pfx, ".z"},       32'(z),         32'(e_z));
        check({pfx, ".busy"},    32'(busy),      32'(e_busy));
        check({pfx, ".done"},    32'(done),      32'(e_done));
        check({pfx, ".err_cfg"}, 32'(err_cfg),   32'(e_err));
        check({pfx, ".cnt"},     32'(match_cnt), 32'(m_cnt));
    endtask

    task automatic tick(input string pfx);
        model_step();
        @(posedge clk);
        #1;
        compare_all(pfx);
    endtask

    task automatic clear_inputs();
        cfg_we = 0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0; cfg_overlap = 0;
        start = 0; abort = 0; x = 0; x_valid = 0;
    endtask

    task automatic write_cfg(input logic [7:0] p, input int l, input int t, input bit ov);
        cfg_we = 1; cfg_pattern = p; cfg_len = LEN_W'(l); cfg_target = CNT_W'(t); cfg_overlap = ov;
        tick("cfg");
        cfg_we = 0;
    endtask

    task automatic do_start(input string pfx);
        start = 1;
        tick(pfx);
        start = 0;
    endtask

    task automatic send(input string pfx, input bit b);
        x_valid = 1; x = b;
        tick(pfx);
        x_valid = 0;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        rst = 1;

        // Overlapping 101, target 2: hits on bits 3 and 5.
        write_cfg(8'b101, 3, 2, 1);
        do_start("t1.start");
        check("t1.busy_arm", 32'(busy), 32'd1);
        tick("t1.arm");
        send("t1", 1); send("t1", 0); send("t1", 1);
        check("t1.z3", 32'(z), 32'd1);
        check("t1.cnt3", 32'(match_cnt), 32'd1);
        send("t1", 0); send("t1", 1);
        check("t1.done5", 32'(done), 32'd1);
        check("t1.cnt5", 32'(match_cnt), 32'd2);
        check("t1.busy5", 32'(busy), 32'd0);
        tick("t1.tail");

        // Non-overlapping: hits on bits 3 and 7 only.
        write_cfg(8'b101, 3, 2, 0);
        do_start("t2.start");
        tick("t2.arm");
        for (int i = 0; i < 7; i++) begin
            send("t2", (i % 2) == 0);
            if (i == 4) check("t2.noz5", 32'(z), 32'd0);
        end
        check("t2.done7", 32'(done), 32'd1);
        tick("t2.tail");

        // Illegal configs: len 0, then target 0.
        write_cfg(8'b1, 0, 1, 1);
        do_start("t3a.start");
        check("t3a.err", 32'(err_cfg), 32'd1);
        check("t3a.busy", 32'(busy), 32'd0);
        tick("t3a.after");
        write_cfg(8'b1, 1, 0, 1);
        do_start("t3b.start");
        check("t3b.err", 32'(err_cfg), 32'd1);
        tick("t3b.after");
        check("t3b.err_gone", 32'(err_cfg), 32'd0);

        // Pattern 11, target 3, x held high with x_valid toggling.
        write_cfg(8'b11, 2, 3, 1);
        do_start("t4.start");
        tick("t4.arm");
        x = 1;
        for (int i = 0; i < 8; i++) begin
            x_valid = (i % 2) == 0;
            tick("t4");
        end
        x_valid = 0;
        tick("t4.tail");

        // Abort on the completing bit; config write while busy is ignored.
        write_cfg(8'b101, 3, 5, 1);
        do_start("t5.start");
        tick("t5.arm");
        write_cfg(8'b0, 1, 1, 0);
        send("t5", 1); send("t5", 0);
        abort = 1; x = 1; x_valid = 1;
        tick("t5.abort");
        abort = 0; x_valid = 0;
        check("t5.abort_z", 32'(z), 32'd0);
        check("t5.abort_busy", 32'(busy), 32'd0);
        do_start("t5.restart");
        tick("t5.arm2");
        send("t5b", 1); send("t5b", 0); send("t5b", 1);
        check("t5.oldcfg_z", 32'(z), 32'd1);

        // Asynchronous reset mid-run, then a fresh run.
        send("t6", 1);
        #2 rst = 0;
        #1;
        model_reset();
        compare_all("t6.async");
        @(posedge clk);
        #1 rst = 1;
        write_cfg(8'b0110, 4, 1, 0);
        do_start("t6.start");
        tick("t6.arm");
        send("t6b", 0); send("t6b", 1); send("t6b", 1); send("t6b", 0);
        check("t6.done", 32'(done), 32'd1);
        tick("t6.tail");

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cfg_we      = ($urandom_range(0, 9) == 0);
            cfg_pattern = PAT_W'($urandom);
            cfg_len     = LEN_W'(($urandom_range(0, 19) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 4));
            cfg_target  = CNT_W'(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4));
            cfg_overlap = $urandom_range(0, 1) == 1;
            start       = ($urandom_range(0, 5) == 0);
            abort       = ($urandom_range(0, 39) == 0);
            x           = $urandom_range(0, 1) == 1;
            x_valid     = ($urandom_range(0, 3) != 0);
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
